// File: rtl/c17_pkg.sv
// c17_pkg
// Shared definitions for the pipelined C17 vector block:
//   - bounds on the pipeline depth
//   - per-bit result pair type and the C17 evaluation function
// The function works on one bit lane. Callers sweep it across the vector
// width, so the package needs no width parameter.
package c17_pkg;

  localparam int unsigned C17_DEPTH_MIN = 1;
  localparam int unsigned C17_DEPTH_MAX = 4;

  // Result of one bit lane: {r22, r23}
  typedef struct packed {
    logic r22;
    logic r23;
  } c17_bit_pair_t;

  // C17 equations on one lane. mode=1 complements both results.
  function automatic c17_bit_pair_t c17_eval(
    input logic g1,
    input logic g2,
    input logic g3,
    input logic g6,
    input logic g7,
    input logic mode
  );
    logic n8;
    logic n9;
    logic n10;
    logic n12;
    c17_bit_pair_t res;
    n8      = g6 & g3;
    n9      = g2 & ~n8;
    n10     = g1 & g3;
    n12     = g7 & ~n8;
    // XOR with mode gives the output polarity select without a branch
    res.r22 = (n9 | n10) ^ mode;
    res.r23 = (n9 | n12) ^ mode;
    return res;
  endfunction

endpackage : c17_pkg

// File: rtl/c17_pipe_stage.sv
// c17_pipe_stage
// One valid/ready register slice.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   up_valid, up_data   : incoming vector from the previous slice or the input
//   up_ready            : this slice can load this cycle
//   dn_valid, dn_data   : registered vector presented to the next slice
//   dn_ready            : next slice (or the consumer) can take dn_data
module c17_pipe_stage #(
  parameter int unsigned PAY_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  input  logic [PAY_W-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [PAY_W-1:0] dn_data,
  input  logic             dn_ready
);

  logic             valid_d;
  logic             valid_q;
  logic [PAY_W-1:0] data_d;
  logic [PAY_W-1:0] data_q;

  // An empty slot, or one whose contents leave this cycle, can load.
  // This term chains combinationally, so a full pipeline still accepts
  // every cycle while the consumer is ready.
  assign up_ready = ~valid_q | dn_ready;

  // Next-state: load on ready. Data is captured only with a valid
  // vector, so bubbles leave the previous contents in place.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (up_ready) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Slice registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= {PAY_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule : c17_pipe_stage

// File: rtl/c17_vec_pipe.sv
// c17_vec_pipe
// Pipelined, vectorised C17 benchmark. The function is evaluated on the
// input side. It is then carried through DEPTH valid/ready slices.
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    : input handshake
//   p_1gat..p_7gat, mode   : WIDTH-bit gate inputs and output polarity
//   out_valid / out_ready  : output handshake (outputs held while stalled)
//   p_22gat, p_23gat       : results, driven from the last slice registers
//   acc_count              : saturating count of accepted input vectors
module c17_vec_pipe
  import c17_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_1gat,
  input  logic [WIDTH-1:0] p_2gat,
  input  logic [WIDTH-1:0] p_3gat,
  input  logic [WIDTH-1:0] p_6gat,
  input  logic [WIDTH-1:0] p_7gat,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_22gat,
  output logic [WIDTH-1:0] p_23gat,
  output logic [CNT_W-1:0] acc_count
);

  localparam int unsigned PAY_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ACC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r22_s;
  logic [WIDTH-1:0] r23_s;
  c17_bit_pair_t    pair_s;

  // Index k is the input side of slice k. Index DEPTH is the consumer side.
  logic [DEPTH:0]   valid_s;
  logic [DEPTH:0]   ready_s;
  logic [PAY_W-1:0] data_s [DEPTH+1];

  logic [CNT_W-1:0] acc_d;
  logic [CNT_W-1:0] acc_q;

  // C17 function swept over every bit lane of the input vectors
  always_comb begin
    r22_s  = {WIDTH{1'b0}};
    r23_s  = {WIDTH{1'b0}};
    pair_s = '{r22: 1'b0, r23: 1'b0};
    for (int i = 0; i < WIDTH; i++) begin
      pair_s   = c17_eval(p_1gat[i], p_2gat[i], p_3gat[i],
                          p_6gat[i], p_7gat[i], mode);
      r22_s[i] = pair_s.r22;
      r23_s[i] = pair_s.r23;
    end
  end

  assign valid_s[0]     = in_valid;
  assign data_s[0]      = {r22_s, r23_s};
  assign ready_s[DEPTH] = out_ready;
  assign in_ready       = ready_s[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    c17_pipe_stage #(
      .PAY_W (PAY_W)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .up_valid (valid_s[k]),
      .up_data  (data_s[k]),
      .up_ready (ready_s[k]),
      .dn_valid (valid_s[k+1]),
      .dn_data  (data_s[k+1]),
      .dn_ready (ready_s[k+1])
    );
  end

  assign out_valid = valid_s[DEPTH];
  assign p_22gat   = data_s[DEPTH][PAY_W-1:WIDTH];
  assign p_23gat   = data_s[DEPTH][WIDTH-1:0];

  // Accepted-vector counter. It sticks at all-ones instead of wrapping.
  always_comb begin
    acc_d = acc_q;
    if (in_valid && ready_s[0] && (acc_q != ACC_MAX)) begin
      acc_d = acc_q + ACC_ONE;
    end else begin
      acc_d = acc_q;
    end
  end

  // Counter register. Reset also wins over a handshake in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= {CNT_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_count = acc_q;

endmodule : c17_vec_pipe

// File: doc/c17_vec_pipe.md
Name: c17_vec_pipe

Overview:
- Parametrised, pipelined successor to the 5-input/2-output C17 benchmark function.
- Evaluates the C17 equations bitwise over WIDTH-bit vector lanes. Adds a DEPTH-stage valid/ready pipeline, a registered output-polarity mode and a saturating transfer counter.
- Serves as a sequential benchmark and regression target alongside the combinational C17 circuit.

Parameters:
- WIDTH, 8, bits per gate input/output lane (≥1)
- DEPTH, 2, pipeline register stages from input handshake to output (1..4)
- CNT_W, 16, width of saturating accepted-vector counter (≥2)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept input this cycle
- p_1gat  in  WIDTH  gate input 1
- p_2gat  in  WIDTH  gate input 2
- p_3gat  in  WIDTH  gate input 3
- p_6gat  in  WIDTH  gate input 6
- p_7gat  in  WIDTH  gate input 7
- mode  in  1  0 = true outputs, 1 = complemented outputs; sampled with data
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts output
- p_22gat  out  WIDTH  result 22
- p_23gat  out  WIDTH  result 23
- acc_count  out  CNT_W  number of accepted input vectors, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Per bit i:
  - n8 = g6&g3
  - n9 = g2&~n8
  - n10 = g1&g3
  - n12 = g7&~n8
  - r22 = n9|n10
  - r23 = n9|n12
- If mode=1, the outputs are ~r22 and ~r23.
- The function is evaluated combinationally before stage 0 register. Stages 1..DEPTH-1 carry data unchanged.
- Each stage k holds v[k] plus data.
  - ready[k] = ~v[k] | ready[k+1].
  - ready[DEPTH] = out_ready.
  - in_ready = ready[0].
- Stage k loads when ready[k] is high. It takes v[k-1] and data from stage k-1, or in_valid and the computed result for k=0.
- Data registers load only when the incoming valid is 1. Otherwise they hold their contents.
- out_valid = v[DEPTH-1]. p_22gat/p_23gat are driven directly from the last stage registers.
- Latency: a vector accepted in cycle t appears with out_valid in cycle t+DEPTH, given no backpressure.
- Throughput is 1 vector/cycle sustained when out_ready=1. A full pipeline with out_ready=1 accepts a new input in the same cycle; the ready chain is combinational.
- Backpressure:
  - out_ready=0 stalls the pipeline.
  - Exactly DEPTH vectors are buffered, then in_ready=0.
  - out_valid stays high and output data is stable while stalled (AXI-style hold).
- Order is strictly FIFO. No vector is dropped or duplicated.
- acc_count increments by 1 on every in_valid&in_ready cycle and saturates at 2^CNT_W-1 with no wrap.
- in_valid while in_ready=0 has no effect. Input data may change freely in that case.
- Reset values, for all outputs:
  - all v[k]=0, so out_valid=0
  - in_ready=1 from the first cycle after reset
  - p_22gat=0, p_23gat=0
  - acc_count=0
- Reset mid-operation discards in-flight vectors. The next cycle shows out_valid=0 regardless of out_ready.
- in_valid during the reset cycle is not accepted and is not counted.

Decomposition:
- Package c17_pkg:
  - function c17_eval(g1,g2,g3,g6,g7,mode) returning {r22,r23} at WIDTH, via a parametrised function or a localparam-sized struct
  - typedef for the stage payload {p22,p23}
  - localparam bounds for DEPTH
- Sub-module c17_pipe_stage: one valid/ready register slice with a WIDTH*2 payload, instantiated DEPTH times via generate.

Test Plan:
- Basic values, WIDTH=8, DEPTH=2, mode=0:
  - g1=F0, g2=CC, g3=AA, g6=FF, g7=0F -> p_22gat=E4, p_23gat=45, out_valid 2 cycles after accept.
  - Same vector with mode=1 -> 1B, BA.
- Extremes: all inputs 00 -> 00/00; all inputs FF -> p_22gat=FF, p_23gat=00. Back-to-back 4 vectors with out_ready=1 -> outputs on 4 consecutive cycles, in order, in_ready constantly 1.
- Backpressure: hold out_ready=0 and offer 3 vectors -> first 2 accepted, in_ready=0 on the 3rd, out_valid=1 with data stable. Raise out_ready -> 3 vectors drain in order and acc_count=3.
- Saturation, CNT_W=4: 20 accepted transfers -> acc_count stays 15 after the 15th.
- Reset mid-flight with DEPTH=4 holding 3 valid vectors: assert reset 1 cycle -> next cycle out_valid=0, acc_count=0, in_ready=1, and no stale vector emerges later.
- Random stimulus over DEPTH=1..4 with random ready/valid against a reference model -> exact sequence match and zero losses.
